// File: rtl/fir_decimate_mac.sv
// Decimating FIR with one shared multiplier and runtime-loadable coefficients.
// A MAC runs only for samples kept by the decimator; the result is shifted and saturated.
module fir_decimate_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int NUM_TAPS   = 16,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          single_valid_in,
    input  logic signed [DATA_WIDTH-1:0]  data_in,
    input  logic [3:0]                    decim_factor,
    input  logic [4:0]                    right_shift,
    input  logic                          coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_WIDTH-1:0]  coef_data,
    input  logic                          overrun_clr,
    output logic                          valid_out,
    output logic signed [DATA_WIDTH-1:0]  data_out,
    output logic                          busy,
    output logic                          overrun
);

    localparam int AW = $clog2(NUM_TAPS);
    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    logic signed [DATA_WIDTH-1:0] samples [NUM_TAPS];
    logic signed [COEF_WIDTH-1:0] coefs   [NUM_TAPS];

    state_t                       state;
    logic [AW-1:0]                wr_ptr;
    logic [AW-1:0]                rd_ptr;
    logic [AW-1:0]                tap;
    logic [3:0]                   phase;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [PW-1:0]         product;
    logic signed [DATA_WIDTH-1:0] sat_val;
    logic [ACC_WIDTH-DATA_WIDTH:0] upper;
    logic                         accept;
    logic                         drop;
    logic                         trigger;
    logic                         coef_ok;

    assign accept  = single_valid_in & ~busy;
    assign drop    = single_valid_in & busy;
    assign trigger = accept & (phase >= decim_factor);
    assign coef_ok = coef_we & ~busy & (coef_addr <= LAST);

    // rd_ptr walks backwards from the newest sample, so tap k meets the k-th older input
    assign product = samples[rd_ptr] * coefs[tap];
    assign shifted = acc >>> right_shift;
    assign upper   = shifted[ACC_WIDTH-1:DATA_WIDTH-1];

    // Clamp when the bits above the output sign are not a pure sign extension
    always_comb begin
        sat_val = shifted[DATA_WIDTH-1:0];
        if (!upper[ACC_WIDTH-DATA_WIDTH] && (|upper)) begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (upper[ACC_WIDTH-DATA_WIDTH] && !(&upper)) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    // Circular delay line: an accepted sample overwrites the oldest slot
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                samples[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (accept) begin
            samples[wr_ptr] <= data_in;
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

    // Coefficient bank, writable only while no MAC is in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coefs[i] <= '0;
            end
        end else if (coef_ok) begin
            coefs[coef_addr] <= coef_data;
        end
    end

    // Decimation phase, busy window and sticky overrun (a drop beats a clear)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase   <= '0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                phase <= trigger ? 4'd0 : phase + 4'd1;
            end
            if (trigger) begin
                busy <= 1'b1;
            end else if (valid_out) begin
                busy <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    // MAC sequencer: one product per cycle, then one cycle to scale and emit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            tap       <= '0;
            acc       <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        rd_ptr <= wr_ptr;
                        tap    <= '0;
                        acc    <= '0;
                        state  <= MAC;
                    end
                end
                MAC: begin
                    acc    <= acc + {{(ACC_WIDTH-PW){product[PW-1]}}, product};
                    rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
                    tap    <= tap + 1'b1;
                    if (tap == LAST) begin
                        state <= OUT;
                    end
                end
                OUT: begin
                    data_out  <= sat_val;
                    valid_out <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimate_mac.sv
// Bench for fir_decimate_mac with NUM_TAPS=4.
// A behavioural model predicts each output value and the cycle it must appear in.
module tb_fir_decimate_mac;

    localparam int NT = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               single_valid_in;
    logic signed [15:0] data_in;
    logic [3:0]         decim_factor;
    logic [4:0]         right_shift;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic signed [15:0] coef_data;
    logic               overrun_clr;
    logic               valid_out;
    logic signed [15:0] data_out;
    logic               busy;
    logic               overrun;

    typedef struct {
        longint d;
        int     c;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     cnt = 0;
    int     phase = 0;
    bit     ovr = 1'b0;
    int     hist[NT];
    int     cm[NT];

    fir_decimate_mac #(
        .DATA_WIDTH(16),
        .COEF_WIDTH(16),
        .NUM_TAPS(NT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .single_valid_in(single_valid_in),
        .data_in(data_in),
        .decim_factor(decim_factor),
        .right_shift(right_shift),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .overrun_clr(overrun_clr),
        .valid_out(valid_out),
        .data_out(data_out),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint calc();
        longint a = 0;
        for (int k = 0; k < NT; k++) begin
            a += longint'(cm[k]) * longint'(hist[k]);
        end
        a = a >>> int'(right_shift);
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        return a;
    endfunction

    task automatic model_reset();
        q.delete();
        cnt = 0;
        phase = 0;
        ovr = 1'b0;
        for (int k = 0; k < NT; k++) begin
            hist[k] = 0;
            cm[k] = 0;
        end
    endtask

    task automatic tick();
        bit bp;
        @(posedge clk);
        cyc++;
        if (rst) begin
            bp = (cnt > 0);
            if (cnt > 0) cnt--;
            if (coef_we && !bp) cm[coef_addr] = int'(coef_data);
            if (single_valid_in && bp) ovr = 1'b1;
            else if (overrun_clr) ovr = 1'b0;
            if (single_valid_in && !bp) begin
                for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = int'(data_in);
                if (phase >= int'(decim_factor)) begin
                    phase = 0;
                    cnt = NT + 2;
                    q.push_back('{d: calc(), c: cyc + NT + 1});
                end else begin
                    phase++;
                end
            end
        end
        #1;
        single_valid_in = 1'b0;
        coef_we = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input int v);
        data_in = 16'(v);
        single_valid_in = 1'b1;
        tick();
    endtask

    task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
        int c[NT];
        c = '{c0, c1, c2, c3};
        for (int k = 0; k < NT; k++) begin
            coef_we = 1'b1;
            coef_addr = 2'(k);
            coef_data = 16'(c[k]);
            tick();
        end
    endtask

    // Every cycle out of reset: busy, overrun and output timing/value against the model
    always @(negedge clk) begin
        bit exp_v;
        if (rst) begin
            chk("busy", busy, cnt > 0);
            chk("overrun", overrun, ovr);
            exp_v = (q.size() > 0) && (q[0].c == cyc);
            chk("valid_out", valid_out, exp_v);
            if (exp_v) chk("data_out", longint'(data_out), q[0].d);
            if (q.size() > 0 && q[0].c <= cyc) void'(q.pop_front());
        end
    end

    initial begin
        rst = 1'b0;
        single_valid_in = 1'b0;
        data_in = '0;
        decim_factor = '0;
        right_shift = '0;
        coef_we = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        overrun_clr = 1'b0;
        model_reset();
        idle(3);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_data_out", longint'(data_out), 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b1;
        idle(2);

        // impulse
        set_coefs(1, 0, 0, 0);
        send(100);
        idle(8);

        // decimate by 4, sum of four inputs
        set_coefs(1, 1, 1, 1);
        decim_factor = 4'd3;
        for (int i = 1; i <= 4; i++) begin
            send(i);
            idle(7);
        end
        idle(2);

        // scaling and floor rounding
        decim_factor = 4'd0;
        right_shift = 5'd2;
        repeat (4) begin
            send(8);
            idle(7);
        end
        right_shift = 5'd1;
        set_coefs(1, 0, 0, 0);
        send(-5);
        idle(8);

        // saturation both ways
        right_shift = 5'd0;
        set_coefs(32767, 32767, 32767, 32767);
        repeat (4) begin
            send(32767);
            idle(7);
        end
        repeat (4) begin
            send(-32768);
            idle(7);
        end

        // overrun, clear, and set winning over clear
        set_coefs(1, 0, 0, 0);
        send(10);
        idle(1);
        send(20);
        chk("overrun_set", overrun, 1);
        idle(8);
        overrun_clr = 1'b1;
        tick();
        chk("overrun_clr", overrun, 0);
        send(30);
        idle(1);
        overrun_clr = 1'b1;
        send(40);
        chk("overrun_set_wins", overrun, 1);
        idle(8);
        overrun_clr = 1'b1;
        tick();

        // reset in the middle of a MAC
        set_coefs(2, 0, 0, 0);
        send(77);
        idle(2);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("abort_valid_out", valid_out, 0);
        chk("abort_data_out", longint'(data_out), 0);
        chk("abort_busy", busy, 0);
        idle(3);
        rst = 1'b1;
        idle(10);
        send(9);
        idle(8);
        set_coefs(1, 0, 0, 0);
        send(55);
        idle(10);

        chk("pending_outputs", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fir_decimate_mac.md
Name: fir_decimate_mac

Overview:
- Parametrised successor to the fixed FIR-plus-decimator chain.
- Single-channel decimating FIR with runtime-loadable coefficients, runtime decimation factor (1..16) and output scaling.
- One time-shared multiplier runs a sequential MAC over NUM_TAPS cycles, only for samples that survive decimation.
- Sits between the sample source and downstream consumers that take single-cycle valid pulses.

Parameters:
DATA_WIDTH, 16, sample width in and out (signed)
COEF_WIDTH, 16, coefficient width (signed)
NUM_TAPS, 16, filter length; legal range 2..64
ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(NUM_TAPS), accumulator width; derived, do not override

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
single_valid_in  input  1  one-cycle strobe, data_in valid
data_in  input  DATA_WIDTH  signed sample
decim_factor  input  4  decimation factor minus 1 (0 means keep every sample, 15 means keep 1 of 16)
right_shift  input  5  arithmetic right shift applied to accumulator
coef_we  input  1  coefficient write strobe
coef_addr  input  $clog2(NUM_TAPS)  tap index; 0 is the newest sample
coef_data  input  COEF_WIDTH  signed coefficient
overrun_clr  input  1  clears overrun flag
valid_out  output  1  one-cycle strobe, data_out valid
data_out  output  DATA_WIDTH  signed filtered, decimated sample
busy  output  1  MAC in progress
overrun  output  1  sticky, an input was dropped

Behaviour:
- Reset (rst low, asynchronous):
  - outputs: valid_out=0, data_out=0, busy=0, overrun=0.
  - internal state: delay line all 0, coefficients all 0, phase counter 0, FSM in IDLE.
- Delay line: circular buffer of NUM_TAPS samples with a write pointer.
  - An accepted input overwrites the oldest entry.
  - Tap k multiplies the sample accepted k inputs ago.
- Accept rule: single_valid_in is accepted only when busy=0.
  - single_valid_in while busy=1 drops the sample, sets overrun=1, and leaves the phase counter unchanged.
- Phase counter: increments on each accepted input.
  - When an accepted input arrives with phase >= decim_factor, the sample is written, phase returns to 0, and a MAC is triggered.
  - Otherwise only the sample is written.
  - decim_factor is sampled at each accepted input. Lowering it below the current phase triggers on the next accepted input.
- FSM: IDLE -> MAC -> OUT -> IDLE.
  - IDLE: wait for a trigger. On trigger, latch the base pointer (the newest sample), clear the accumulator, go to MAC.
  - MAC: exactly NUM_TAPS cycles, one product per cycle (acc += coef[k] * sample[k], k = 0..NUM_TAPS-1), then go to OUT.
  - OUT: one cycle. Register data_out = sat(acc >>> right_shift), pulse valid_out, return to IDLE.
- busy=1 from the cycle after the trigger through the OUT cycle inclusive.
- Latency: valid_out rises exactly NUM_TAPS+2 cycles after the triggering single_valid_in cycle.
  - Back-to-back outputs are spaced by at least NUM_TAPS+2 cycles.
- Arithmetic:
  - Products are full precision, summed in ACC_WIDTH with no internal wrap.
  - The shift is arithmetic (floor toward minus infinity).
  - Saturation: values above 2^(DATA_WIDTH-1)-1 clamp to max; values below -2^(DATA_WIDTH-1) clamp to min.
  - right_shift and coefficients are sampled throughout MAC/OUT and must be held stable by the user while busy.
- Coefficient writes:
  - coef_we with busy=0 writes coef[coef_addr] at the clock edge.
  - coef_we while busy=1 is ignored, with no flag.
  - A write in the same cycle as a triggering input is accepted; the new value is used in this MAC.
- overrun_clr clears overrun. If overrun_clr and a drop occur in the same cycle, set wins (overrun=1).
- data_out holds its last value between valid_out pulses.
- Reset mid-MAC aborts the computation; no valid_out is produced afterward.

Test Plan:
- Reset and impulse. Setup: NUM_TAPS=4, coefs {1,0,0,0}, decim_factor=0, right_shift=0. Stimulus: single input 100. Response: valid_out one cycle at +6 cycles, data_out=100; busy high for cycles +1..+6.
- Decimation and sum. Setup: coefs all 1, decim_factor=3. Stimulus: inputs 1,2,3,4, each spaced 8 cycles. Response: exactly one valid_out, 6 cycles after input 4, with data_out=10; no output after inputs 1–3.
- Scaling and rounding. Setup: coefs all 1, decim_factor=0, right_shift=2. Stimulus: four inputs of 8. Response: 4th output = 8. Then right_shift=1, coef {1,0,0,0}, input -5. Response: output = -3.
- Saturation. Setup: all coefs 0x7FFF. Stimulus: four inputs 0x7FFF, right_shift=0. Response: data_out=0x7FFF. Stimulus: four inputs 0x8000. Response: data_out=0x8000.
- Overrun. Stimulus: with decim_factor=0, send an input, then another 2 cycles later. Response: second input dropped, overrun=1, one valid_out only. Then overrun_clr pulse clears overrun; overrun_clr in the same cycle as a drop leaves overrun=1.
- Reset mid-MAC. Stimulus: trigger a MAC, assert rst low at +3 cycles. Response: valid_out, data_out and busy go 0 immediately; no valid_out afterward. Next impulse after release yields a correct result with coefficients reloaded.
